// File: rtl/layer1_pkg.sv
// layer1_pkg: shared types, constants and dimension helpers for the layer-1 controllers
package layer1_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int K = 3;
  function automatic int out_dim(input int in, input int stride);
    return (in - K) / stride + 1;
  endfunction
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/conv_addr_l1.sv
// conv_addr_l1: feature-map and weight read addresses for one kernel tap
module conv_addr_l1 #(
  parameter int IN_W   = 16,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 8,
  parameter int CW     = 4,
  parameter int RW     = 4
) (
  input  logic [RW-1:0]     row,
  input  logic [CW-1:0]     col,
  input  logic [1:0]        i,
  input  logic [1:0]        j,
  output logic [ADDR_W-1:0] fm_addr,
  output logic [3:0]        w_addr
);
  assign fm_addr = ADDR_W'((32'(row) * 32'(STRIDE) + 32'(i)) * 32'(IN_W) + 32'(col) * 32'(STRIDE) + 32'(j));
  assign w_addr  = 4'(i) * 4'd3 + 4'(j);
endmodule

// File: rtl/conv_loop_ctrl_l1.sv
// conv_loop_ctrl_l1: layer-1 convolution loop nest (kernel row, output column, output row)
module conv_loop_ctrl_l1
  import layer1_pkg::*;
#(
  parameter  int IN_W   = 16,
  parameter  int IN_H   = 16,
  parameter  int STRIDE = 1,
  parameter  int ADDR_W = 8,
  localparam int OUT_W  = out_dim(IN_W, STRIDE),
  localparam int OUT_H  = out_dim(IN_H, STRIDE),
  localparam int CW     = cw(OUT_W),
  localparam int RW     = cw(OUT_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        j,
  input  logic              j_zero,
  output logic              temp_zero,
  output logic [1:0]        i,
  output logic [CW-1:0]     col,
  output logic [RW-1:0]     row,
  output logic [ADDR_W-1:0] fm_addr,
  output logic [3:0]        w_addr,
  output logic              acc_clr,
  output logic              acc_valid,
  output logic              busy,
  output logic              done
);
  state_t        r_state, w_nxt;
  logic [1:0]    r_i;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_acc_valid;
  logic          w_run, w_launch, w_tap8, w_col_last, w_row_last;
  always_comb begin
    w_run      = r_state == RUN;
    w_launch   = r_state == IDLE && start;
    w_tap8     = w_run && j_zero && r_i == 2'd2;
    w_col_last = r_col == CW'(OUT_W - 1);
    w_row_last = r_row == RW'(OUT_H - 1);
    w_nxt      = w_launch ? RUN :
                 (w_tap8 && w_col_last && w_row_last) ? DONE :
                 (r_state == DONE) ? IDLE : r_state;
  end
  // Counters wrap fully on the final tap so a finished frame leaves them at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_i         <= 2'd0;
      r_col       <= '0;
      r_row       <= '0;
      r_acc_valid <= 1'b0;
    end else begin
      r_state     <= w_nxt;
      r_acc_valid <= w_tap8;
      if (w_launch) begin
        r_i   <= 2'd0;
        r_col <= '0;
        r_row <= '0;
      end else if (w_run && j_zero) begin
        r_i <= (r_i == 2'd2) ? 2'd0 : r_i + 2'd1;
        if (r_i == 2'd2) begin
          r_col <= w_col_last ? '0 : r_col + CW'(1);
          if (w_col_last) r_row <= w_row_last ? '0 : r_row + RW'(1);
        end
      end
    end
  end
  conv_addr_l1 #(.IN_W(IN_W), .STRIDE(STRIDE), .ADDR_W(ADDR_W), .CW(CW), .RW(RW)) u_addr (
    .row(r_row), .col(r_col), .i(r_i), .j(j), .fm_addr(fm_addr), .w_addr(w_addr)
  );
  assign temp_zero = !w_run;
  assign busy      = w_run;
  assign done      = r_state == DONE;
  assign acc_valid = r_acc_valid;
  assign acc_clr   = w_run && r_i == 2'd0 && j == 2'd0;
  assign i         = r_i;
  assign col       = r_col;
  assign row       = r_row;
endmodule

// File: tb/tb_conv_loop_ctrl_l1.sv
// tb_conv_loop_ctrl_l1: two controllers (5x5 stride 1, 7x7 stride 2) against a tap-index model
module tb_conv_loop_ctrl_l1;
  logic clk = 0, rst = 0, start = 0, jzf = 0;
  logic [1:0] ja, jb;
  logic jza, jzb;
  logic tza, clra, ava, busya, donea, tzb, clrb, avb, busyb, doneb;
  logic [1:0] ia, cola, rowa, ib, colb, rowb;
  logic [7:0] fma, fmb;
  logic [3:0] wa, wb;
  int n_chk = 0, n_err = 0;
  int m_st, m_t, cyc = 0, bcnt, avcnt, last_av;
  bit m_av, m_zero;

  always #5 clk = ~clk;

  // external kernel-column counters, cleared by each controller's temp_zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ja <= 2'd0;
      jb <= 2'd0;
    end else begin
      ja <= (tza || ja == 2'd2) ? 2'd0 : ja + 2'd1;
      jb <= (tzb || jb == 2'd2) ? 2'd0 : jb + 2'd1;
    end
  end
  assign jza = ja == 2'd2 || jzf;
  assign jzb = jb == 2'd2 || jzf;

  conv_loop_ctrl_l1 #(.IN_W(5), .IN_H(5), .STRIDE(1), .ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .j(ja), .j_zero(jza), .temp_zero(tza), .i(ia),
    .col(cola), .row(rowa), .fm_addr(fma), .w_addr(wa), .acc_clr(clra), .acc_valid(ava),
    .busy(busya), .done(donea));
  conv_loop_ctrl_l1 #(.IN_W(7), .IN_H(7), .STRIDE(2), .ADDR_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .j(jb), .j_zero(jzb), .temp_zero(tzb), .i(ib),
    .col(colb), .row(rowb), .fm_addr(fmb), .w_addr(wb), .acc_clr(clrb), .acc_valid(avb),
    .busy(busyb), .done(doneb));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic int fm_of(input int in_w, input int s, input int t);
    int p, k;
    p = t / 9;
    k = t % 9;
    return ((p / 3) * s + k / 3) * in_w + (p % 3) * s + k % 3;
  endfunction

  task automatic model_reset();
    m_st = 0; m_t = 0; m_av = 0; m_zero = 1; bcnt = 0; avcnt = 0;
  endtask

  task automatic model_step();
    bit nav;
    if (!rst) return;
    nav = m_st == 1 && m_t % 9 == 8;
    case (m_st)
      0: if (start) begin m_st = 1; m_t = 0; m_zero = 0; end
      1: if (m_t == 80) m_st = 2; else m_t++;
      default: m_st = 0;
    endcase
    m_av = nav;
  endtask

  task automatic compare();
    int k, p;
    chk("busy_a", busya, m_st == 1);
    chk("busy_b", busyb, m_st == 1);
    chk("tz_a", tza, m_st != 1);
    chk("tz_b", tzb, m_st != 1);
    chk("done_a", donea, m_st == 2);
    chk("done_b", doneb, m_st == 2);
    chk("av_a", ava, m_av);
    chk("av_b", avb, m_av);
    chk("clr_a", clra, m_st == 1 && m_t % 9 == 0);
    chk("clr_b", clrb, m_st == 1 && m_t % 9 == 0);
    if (m_st == 1) begin
      k = m_t % 9;
      p = m_t / 9;
      chk("i_a", ia, k / 3);
      chk("col_a", cola, p % 3);
      chk("row_a", rowa, p / 3);
      chk("i_b", ib, k / 3);
      chk("col_b", colb, p % 3);
      chk("row_b", rowb, p / 3);
      chk("fm_a", fma, fm_of(5, 1, m_t));
      chk("fm_b", fmb, fm_of(7, 2, m_t));
      chk("w_a", wa, k);
      chk("w_b", wb, k);
      if (m_t == 5 * 9 + 8) begin
        chk("fm_a_r1c2", fma, 19);
        chk("w_a_r1c2", wa, 8);
      end
      if (m_t == 7 * 9 + 1) chk("fm_b_r2c1", fmb, 31);
    end
    if (m_zero) begin
      chk("zero_pos_a", {ia, cola, rowa}, 0);
      chk("zero_pos_b", {ib, colb, rowb}, 0);
      chk("zero_addr_a", {fma, wa}, 0);
      chk("zero_addr_b", {fmb, wb}, 0);
    end
    if (busya) bcnt++;
    if (ava) begin
      if (avcnt > 0) chk("av_gap", cyc - last_av, 9);
      last_av = cyc;
      avcnt++;
    end
    if (donea) begin
      chk("done_with_av", ava, 1);
      chk("frame_len", bcnt, 81);
      chk("frame_av", avcnt, 9);
      bcnt = 0;
      avcnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare();
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200 && (busya || donea); n++) tick();
    chk("idle_timeout", busya || donea, 0);
  endtask

  task automatic abort();
    rst = 0;
    #1;
    model_reset();
    compare();
    tick();
    rst = 1;
  endtask

  task automatic frame();
    jzf = 0;
    start = 1;
    tick();
    start = 0;
    wait_idle();
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    rst = 1;
    repeat (20) tick();
    jzf = 1;
    repeat (5) tick();
    jzf = 0;
    tick();
    frame();
    start = 1;
    repeat (86) tick();
    start = 0;
    wait_idle();
    start = 1;
    tick();
    start = 0;
    repeat (39) tick();
    abort();
    repeat (3) tick();
    frame();
    repeat (12) begin
      repeat ($urandom_range(0, 4)) begin
        jzf = 1'($urandom_range(0, 1));
        tick();
      end
      jzf = 0;
      start = 1;
      repeat ($urandom_range(1, 3)) tick();
      start = 0;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 60)) tick();
        abort();
      end else wait_idle();
    end
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
